ddfs_sweep_ctrl: RTL and testbench
==================================

// Module: ddfs_sweep_ctrl
// PURPOSE
// Sequencer that configures and drives one ddfs instance. Latches a sweep config from the
// host, then steps the ddfs frequency word from a start to a stop value with a programmable
// dwell per step. Supports one-shot, repeat and ping-pong sweeps.
// Also drives the waveform select, mirror and freq_cntrl inputs of the ddfs from the config.
// PARAMETERS
// FW_WIDTH     7   width of frequency word (matches ddfs fw)
// DWELL_WIDTH  16  width of dwell counter (clk cycles per step)
// PORTS
// clk            in   1            system clock, same clock as the ddfs
// rst_n          in   1            asynchronous reset, active low
// cfg_valid      in   1            config offer; accepted when cfg_valid & cfg_ready
// cfg_ready      out  1            high only in IDLE
// cfg_fw_start   in   FW_WIDTH     first frequency word of sweep
// cfg_fw_stop    in   FW_WIDTH     last frequency word of sweep
// cfg_fw_step    in   FW_WIDTH     step magnitude; 0 is treated as 1
// cfg_dwell      in   DWELL_WIDTH  cycles each fw is held; 0 is treated as 1
// cfg_mode       in   2            00 one-shot, 01 repeat, 10 ping-pong, 11 = one-shot
// cfg_wave       in   2            00 square, 01 triangular, 10 sinusoidal, 11 = square
// cfg_mirror     in   2            {mirror_x, mirror_y}
// cfg_freq_cntrl in   3            passed to ddfs freq_cntrl
// start          in   1            begin sweep (IDLE only)
// hold           in   1            freeze sweep while high (RUN <-> HOLD)
// abort          in   1            stop sweep, return to IDLE
// fw             out  FW_WIDTH     ddfs frequency word
// sin, triang    out  1 each       ddfs wave selects, one-hot or both 0 (square)
// mirror_x/_y    out  1 each       ddfs mirror controls
// freq_cntrl     out  3            ddfs clock divider select
// busy           out  1            high in RUN and HOLD
// done           out  1            one-cycle pulse at end of a one-shot sweep
// BEHAVIOUR
// - All outputs are registered. Reset: IDLE, fw=0, sin=0, triang=0, mirror_x=0, mirror_y=0,
//   freq_cntrl=0, busy=0, done=0, cfg_ready=1. Shadow config = all zero.
// - States: IDLE, RUN, HOLD, DONE.
// - IDLE: a cfg handshake on edge T latches the shadow config. From T+1, fw=cfg_fw_start and
//   wave/mirror/freq_cntrl follow the new config. cfg_valid outside IDLE is ignored.
// - IDLE & start -> RUN. When cfg handshake and start occur on the same edge, the sweep uses
//   the new config. fw is reloaded to start. Direction = up if start<=stop, else down.
// - RUN: dwell counter loads D-1, where D=max(cfg_dwell,1). It decrements each cycle. At 0,
//   fw advances on that edge, so each fw value is held exactly D cycles.
// - Advance uses FW_WIDTH+1-bit arithmetic. next = fw +/- step; if next passes stop, clamp
//   to stop. No wrap-around, ever.
// - Dwell expiry with fw==stop:
//   - one-shot -> DONE.
//   - repeat -> fw=start, continue.
//   - ping-pong -> swap start/stop internally, reverse direction, step toward the other end.
// - start==stop: fw is constant. The one-shot ends after D cycles; repeat/ping-pong run
//   until abort.
// - HOLD: entered from RUN while hold=1. fw and dwell counter are frozen. Returns to RUN when
//   hold=0 and resumes the remaining dwell count.
// - DONE: done=1, busy=0, fw stays at stop for one cycle, then IDLE.
// - abort (RUN/HOLD/DONE) -> IDLE next edge. fw holds its current value; done is not pulsed.
//   abort beats hold; start is ignored unless in IDLE.
// - Async reset mid-sweep returns immediately to reset values; the shadow config is lost.
// TESTING
// - start=10 stop=20 step=5 dwell=3 one-shot, start on edge 0 -> fw 10 for cycles 1-3,
//   15 for 4-6, 20 for 7-9; done=1 on cycle 10 only; busy 0 from cycle 10.
// - start=20 stop=3 step=8 dwell=1 one-shot -> fw 20,12,4,3 (clamped), then done pulse.
// - start=0 stop=127 step=100 dwell=2 ping-pong -> fw 0,0,100,100,127,127,27,27,0,0,100...,
//   no overflow.
// - RUN at fw=15 mid-dwell, hold high 5 cycles -> fw frozen 5 cycles, remaining dwell
//   resumes; then abort -> IDLE, fw=15, done=0.
// - cfg_valid while busy -> cfg_ready=0, shadow config unchanged. cfg_wave=10 in IDLE ->
//   sin=1, triang=0 next cycle.
// - rst_n low mid-sweep -> all outputs at reset values asynchronously; after release
//   start=1 -> sweep of an all-zero config (fw=0).

Source files
------------

// File: rtl/ddfs_sweep_ctrl_if.sv
// Host-side bundle for the ddfs sweep controller: config offer, sweep controls,
// and the registered drive/status signals that go to the ddfs and back to the host.
interface ddfs_sweep_ctrl_if #(
  parameter int FW_WIDTH    = 7,
  parameter int DWELL_WIDTH = 16
);
  logic                   cfg_valid;
  logic                   cfg_ready;
  logic [FW_WIDTH-1:0]    cfg_fw_start;
  logic [FW_WIDTH-1:0]    cfg_fw_stop;
  logic [FW_WIDTH-1:0]    cfg_fw_step;
  logic [DWELL_WIDTH-1:0] cfg_dwell;
  logic [1:0]             cfg_mode;
  logic [1:0]             cfg_wave;
  logic [1:0]             cfg_mirror;
  logic [2:0]             cfg_freq_cntrl;
  logic                   start;
  logic                   hold;
  logic                   abort;
  logic [FW_WIDTH-1:0]    fw;
  logic                   sin;
  logic                   triang;
  logic                   mirror_x;
  logic                   mirror_y;
  logic [2:0]             freq_cntrl;
  logic                   busy;
  logic                   done;

  modport master (
    output cfg_valid, cfg_fw_start, cfg_fw_stop, cfg_fw_step, cfg_dwell,
           cfg_mode, cfg_wave, cfg_mirror, cfg_freq_cntrl, start, hold, abort,
    input  cfg_ready, fw, sin, triang, mirror_x, mirror_y, freq_cntrl, busy, done
  );

  modport slave (
    input  cfg_valid, cfg_fw_start, cfg_fw_stop, cfg_fw_step, cfg_dwell,
           cfg_mode, cfg_wave, cfg_mirror, cfg_freq_cntrl, start, hold, abort,
    output cfg_ready, fw, sin, triang, mirror_x, mirror_y, freq_cntrl, busy, done
  );
endinterface

// File: rtl/ddfs_sweep_ctrl.sv
// Sweep sequencer for one ddfs: latches a host config, then steps the frequency word
// from start to stop with a per-step dwell in one-shot, repeat or ping-pong fashion.
module ddfs_sweep_ctrl #(
  parameter int FW_WIDTH    = 7,
  parameter int DWELL_WIDTH = 16
) (
  input logic              clk,
  input logic              rst_n,
  ddfs_sweep_ctrl_if.slave bus
);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_HOLD = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]             r_state;
  logic [FW_WIDTH-1:0]    r_fw;
  logic [DWELL_WIDTH-1:0] r_cnt;
  logic [DWELL_WIDTH-1:0] r_dwell_m1;
  logic [FW_WIDTH-1:0]    r_step;
  logic [FW_WIDTH-1:0]    r_cur_start;
  logic [FW_WIDTH-1:0]    r_cur_stop;
  logic                   r_dir;
  logic [FW_WIDTH-1:0]    r_cfg_start;
  logic [FW_WIDTH-1:0]    r_cfg_stop;
  logic [FW_WIDTH-1:0]    r_cfg_step;
  logic [DWELL_WIDTH-1:0] r_cfg_dwell;
  logic [1:0]             r_cfg_mode;
  logic                   r_sin;
  logic                   r_triang;
  logic                   r_mirror_x;
  logic                   r_mirror_y;
  logic [2:0]             r_freq_cntrl;
  logic                   r_busy;
  logic                   r_done;
  logic                   r_cfg_ready;

  logic                   w_take_cfg;
  logic [FW_WIDTH-1:0]    w_eff_start;
  logic [FW_WIDTH-1:0]    w_eff_stop;
  logic [FW_WIDTH-1:0]    w_raw_step;
  logic [FW_WIDTH-1:0]    w_eff_step;
  logic [DWELL_WIDTH-1:0] w_raw_dwell;
  logic [DWELL_WIDTH-1:0] w_eff_dwell_m1;
  logic                   w_at_stop;
  logic [FW_WIDTH-1:0]    w_adv_fw;
  logic [FW_WIDTH-1:0]    w_rev_fw;

  // One step from 'from' toward 'target' in FW_WIDTH+1 bits, clamped so it never passes or wraps.
  function automatic logic [FW_WIDTH-1:0] f_advance(
    input logic [FW_WIDTH-1:0] from,
    input logic [FW_WIDTH-1:0] target,
    input logic [FW_WIDTH-1:0] step,
    input logic                up
  );
    logic [FW_WIDTH:0] sum;
    if (up) begin
      sum = {1'b0, from} + {1'b0, step};
      return (sum > {1'b0, target}) ? target : sum[FW_WIDTH-1:0];
    end else begin
      sum = {1'b0, from} - {1'b0, step};
      return (sum[FW_WIDTH] || (sum < {1'b0, target})) ? target : sum[FW_WIDTH-1:0];
    end
  endfunction

  // A handshake on the same edge as start must feed the new config straight into the sweep.
  assign w_take_cfg     = (r_state == S_IDLE) && bus.cfg_valid;
  assign w_eff_start    = w_take_cfg ? bus.cfg_fw_start : r_cfg_start;
  assign w_eff_stop     = w_take_cfg ? bus.cfg_fw_stop  : r_cfg_stop;
  assign w_raw_step     = w_take_cfg ? bus.cfg_fw_step  : r_cfg_step;
  assign w_raw_dwell    = w_take_cfg ? bus.cfg_dwell    : r_cfg_dwell;
  assign w_eff_step     = (w_raw_step == '0) ? FW_WIDTH'(1) : w_raw_step;
  assign w_eff_dwell_m1 = (w_raw_dwell == '0) ? '0 : w_raw_dwell - 1'b1;

  assign w_at_stop = (r_fw == r_cur_stop);
  assign w_adv_fw  = f_advance(r_fw, r_cur_stop, r_step, r_dir);
  assign w_rev_fw  = f_advance(r_cur_stop, r_cur_start, r_step, !r_dir);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_fw         <= '0;
      r_cnt        <= '0;
      r_dwell_m1   <= '0;
      r_step       <= '0;
      r_cur_start  <= '0;
      r_cur_stop   <= '0;
      r_dir        <= 1'b0;
      r_cfg_start  <= '0;
      r_cfg_stop   <= '0;
      r_cfg_step   <= '0;
      r_cfg_dwell  <= '0;
      r_cfg_mode   <= '0;
      r_sin        <= 1'b0;
      r_triang     <= 1'b0;
      r_mirror_x   <= 1'b0;
      r_mirror_y   <= 1'b0;
      r_freq_cntrl <= '0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_cfg_ready  <= 1'b1;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_take_cfg) begin
            r_cfg_start  <= bus.cfg_fw_start;
            r_cfg_stop   <= bus.cfg_fw_stop;
            r_cfg_step   <= bus.cfg_fw_step;
            r_cfg_dwell  <= bus.cfg_dwell;
            r_cfg_mode   <= bus.cfg_mode;
            r_fw         <= bus.cfg_fw_start;
            r_sin        <= (bus.cfg_wave == 2'b10);
            r_triang     <= (bus.cfg_wave == 2'b01);
            r_mirror_x   <= bus.cfg_mirror[1];
            r_mirror_y   <= bus.cfg_mirror[0];
            r_freq_cntrl <= bus.cfg_freq_cntrl;
          end
          if (bus.start) begin
            r_state     <= S_RUN;
            r_busy      <= 1'b1;
            r_cfg_ready <= 1'b0;
            r_fw        <= w_eff_start;
            r_cur_start <= w_eff_start;
            r_cur_stop  <= w_eff_stop;
            r_step      <= w_eff_step;
            r_dwell_m1  <= w_eff_dwell_m1;
            r_cnt       <= w_eff_dwell_m1;
            r_dir       <= (w_eff_start <= w_eff_stop);
          end
        end
        S_RUN, S_HOLD: begin
          if (bus.abort) begin
            r_state     <= S_IDLE;
            r_busy      <= 1'b0;
            r_cfg_ready <= 1'b1;
          end else if (bus.hold) begin
            r_state <= S_HOLD;
          end else begin
            r_state <= S_RUN;
            if (r_cnt != '0) begin
              r_cnt <= r_cnt - 1'b1;
            end else begin
              r_cnt <= r_dwell_m1;
              if (!w_at_stop) begin
                r_fw <= w_adv_fw;
              end else begin
                // End of a leg: mode 11 falls into the one-shot default.
                case (r_cfg_mode)
                  2'b01: r_fw <= r_cur_start;
                  2'b10: begin
                    r_fw        <= w_rev_fw;
                    r_cur_start <= r_cur_stop;
                    r_cur_stop  <= r_cur_start;
                    r_dir       <= !r_dir;
                  end
                  default: begin
                    r_state <= S_DONE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b1;
                  end
                endcase
              end
            end
          end
        end
        default: begin
          r_state     <= S_IDLE;
          r_cfg_ready <= 1'b1;
        end
      endcase
    end
  end

  assign bus.cfg_ready  = r_cfg_ready;
  assign bus.fw         = r_fw;
  assign bus.sin        = r_sin;
  assign bus.triang     = r_triang;
  assign bus.mirror_x   = r_mirror_x;
  assign bus.mirror_y   = r_mirror_y;
  assign bus.freq_cntrl = r_freq_cntrl;
  assign bus.busy       = r_busy;
  assign bus.done       = r_done;
endmodule

// File: tb/tb_ddfs_sweep_ctrl.sv
// Bench for ddfs_sweep_ctrl: directed scenarios with literal expectations, then random
// traffic, all compared every cycle against a list-based sweep model.
module tb_ddfs_sweep_ctrl;
  localparam int FW = 7;
  localparam int DW = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  ddfs_sweep_ctrl_if #(.FW_WIDTH(FW), .DWELL_WIDTH(DW)) ifc ();

  ddfs_sweep_ctrl #(.FW_WIDTH(FW), .DWELL_WIDTH(DW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifc)
  );

  int checkCount = 0;
  int errorCount = 0;
  bit compareEnable = 1'b0;

  int mStart, mStop, mStep, mDwell, mMode, mWave, mMirror, mFreq;
  int mFw, mIdx, mHeld, mD, mRunStep;
  bit mBusy, mDone;
  int mSeq[$];

  int exp1[11] = '{10, 10, 10, 15, 15, 15, 20, 20, 20, 20, 20};
  int exp2[5]  = '{20, 12, 4, 3, 3};
  int exp3[12] = '{0, 0, 100, 100, 127, 127, 27, 27, 0, 0, 100, 100};

  task automatic checkOutput(input string name, input int actual, input int expected);
    checkCount++;
    if (actual !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s at %0t: got %0d, expected %0d", name, $time, actual, expected);
    end
  endtask

  // Every fw value one leg visits, from a toward b, clamped at b.
  task automatic buildSeq(input int a, input int b, input int st);
    int v;
    v = a;
    mSeq.delete();
    mSeq.push_back(v);
    while (v != b) begin
      if (a <= b) v = (v + st > b) ? b : v + st;
      else        v = (v - st < b) ? b : v - st;
      mSeq.push_back(v);
    end
  endtask

  task automatic modelStep();
    int a, b;
    if (mDone) begin
      mDone = 1'b0;
    end else if (!mBusy) begin
      if (ifc.cfg_valid) begin
        mStart  = int'(ifc.cfg_fw_start);
        mStop   = int'(ifc.cfg_fw_stop);
        mStep   = int'(ifc.cfg_fw_step);
        mDwell  = int'(ifc.cfg_dwell);
        mMode   = int'(ifc.cfg_mode);
        mWave   = int'(ifc.cfg_wave);
        mMirror = int'(ifc.cfg_mirror);
        mFreq   = int'(ifc.cfg_freq_cntrl);
        mFw     = mStart;
      end
      if (ifc.start) begin
        mRunStep = (mStep == 0) ? 1 : mStep;
        mD       = (mDwell == 0) ? 1 : mDwell;
        buildSeq(mStart, mStop, mRunStep);
        mIdx  = 0;
        mHeld = 0;
        mFw   = mSeq[0];
        mBusy = 1'b1;
      end
    end else if (ifc.abort) begin
      mBusy = 1'b0;
    end else if (!ifc.hold) begin
      mHeld++;
      if (mHeld == mD) begin
        mHeld = 0;
        if (mIdx < mSeq.size() - 1) begin
          mIdx++;
        end else if (mMode == 1) begin
          mIdx = 0;
        end else if (mMode == 2) begin
          a = mSeq[mSeq.size() - 1];
          b = mSeq[0];
          buildSeq(a, b, mRunStep);
          mIdx = (mSeq.size() > 1) ? 1 : 0;
        end else begin
          mBusy = 1'b0;
          mDone = 1'b1;
        end
        if (mBusy) mFw = mSeq[mIdx];
      end
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mStart = 0; mStop = 0; mStep = 0; mDwell = 0;
      mMode = 0; mWave = 0; mMirror = 0; mFreq = 0;
      mFw = 0; mIdx = 0; mHeld = 0; mD = 1; mRunStep = 1;
      mBusy = 1'b0; mDone = 1'b0;
      mSeq.delete();
    end else begin
      modelStep();
    end
  end

  always @(negedge clk) begin
    if (compareEnable) begin
      checkOutput("fw",         int'(ifc.fw),         mFw);
      checkOutput("busy",       int'(ifc.busy),       int'(mBusy));
      checkOutput("done",       int'(ifc.done),       int'(mDone));
      checkOutput("cfg_ready",  int'(ifc.cfg_ready),  int'(!mBusy && !mDone));
      checkOutput("sin",        int'(ifc.sin),        int'(mWave == 2));
      checkOutput("triang",     int'(ifc.triang),     int'(mWave == 1));
      checkOutput("mirror_x",   int'(ifc.mirror_x),   (mMirror >> 1) & 1);
      checkOutput("mirror_y",   int'(ifc.mirror_y),   mMirror & 1);
      checkOutput("freq_cntrl", int'(ifc.freq_cntrl), mFreq);
    end
  end

  task automatic setCfg(input int st, input int sp, input int stp, input int dw,
                        input int md, input int wv, input int mr, input int fc);
    ifc.cfg_fw_start   = FW'(st);
    ifc.cfg_fw_stop    = FW'(sp);
    ifc.cfg_fw_step    = FW'(stp);
    ifc.cfg_dwell      = DW'(dw);
    ifc.cfg_mode       = 2'(md);
    ifc.cfg_wave       = 2'(wv);
    ifc.cfg_mirror     = 2'(mr);
    ifc.cfg_freq_cntrl = 3'(fc);
  endtask

  // Drive one edge's worth of controls and return at the following negedge.
  task automatic applyStimulus(input bit v, input bit s, input bit h, input bit a);
    ifc.cfg_valid = v;
    ifc.start     = s;
    ifc.hold      = h;
    ifc.abort     = a;
    @(negedge clk);
  endtask

  initial begin
    ifc.cfg_valid = 1'b0; ifc.start = 1'b0; ifc.hold = 1'b0; ifc.abort = 1'b0;
    setCfg(0, 0, 0, 0, 0, 0, 0, 0);
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    compareEnable = 1'b1;
    checkOutput("reset_fw",    int'(ifc.fw),        0);
    checkOutput("reset_ready", int'(ifc.cfg_ready), 1);
    checkOutput("reset_busy",  int'(ifc.busy),      0);

    $display("[TB] one-shot up sweep");
    setCfg(10, 20, 5, 3, 0, 0, 0, 0);
    applyStimulus(1, 1, 0, 0);
    for (int k = 1; k <= 11; k++) begin
      checkOutput("os_up_fw",   int'(ifc.fw),   exp1[k-1]);
      checkOutput("os_up_done", int'(ifc.done), (k == 10) ? 1 : 0);
      checkOutput("os_up_busy", int'(ifc.busy), (k <= 9) ? 1 : 0);
      if (k < 11) applyStimulus(0, 0, 0, 0);
    end

    $display("[TB] one-shot down sweep with clamp");
    setCfg(20, 3, 8, 1, 0, 0, 0, 0);
    applyStimulus(1, 1, 0, 0);
    for (int k = 1; k <= 5; k++) begin
      checkOutput("os_dn_fw",   int'(ifc.fw),   exp2[k-1]);
      checkOutput("os_dn_done", int'(ifc.done), (k == 5) ? 1 : 0);
      applyStimulus(0, 0, 0, 0);
    end

    $display("[TB] ping-pong across full range");
    setCfg(0, 127, 100, 2, 2, 0, 0, 0);
    applyStimulus(1, 1, 0, 0);
    for (int k = 1; k <= 12; k++) begin
      checkOutput("pp_fw", int'(ifc.fw), exp3[k-1]);
      if (k < 12) applyStimulus(0, 0, 0, 0);
    end
    applyStimulus(0, 0, 0, 1);
    checkOutput("pp_abort_fw",   int'(ifc.fw),   100);
    checkOutput("pp_abort_busy", int'(ifc.busy), 0);

    $display("[TB] hold then abort");
    setCfg(5, 40, 10, 4, 1, 1, 2, 5);
    applyStimulus(1, 1, 0, 0);
    checkOutput("hold_triang",   int'(ifc.triang),     1);
    checkOutput("hold_mirror_x", int'(ifc.mirror_x),   1);
    checkOutput("hold_freq",     int'(ifc.freq_cntrl), 5);
    repeat (4) applyStimulus(0, 0, 0, 0);
    checkOutput("hold_pre_fw", int'(ifc.fw), 15);
    for (int k = 0; k < 5; k++) begin
      applyStimulus(0, 0, 1, 0);
      checkOutput("hold_frozen_fw", int'(ifc.fw), 15);
    end
    applyStimulus(0, 0, 0, 0);
    checkOutput("hold_resume_fw", int'(ifc.fw), 15);
    applyStimulus(0, 0, 0, 1);
    checkOutput("abort_fw",    int'(ifc.fw),        15);
    checkOutput("abort_done",  int'(ifc.done),      0);
    checkOutput("abort_ready", int'(ifc.cfg_ready), 1);

    $display("[TB] config ignored while busy");
    applyStimulus(0, 1, 0, 0);
    setCfg(60, 70, 1, 1, 0, 2, 3, 7);
    applyStimulus(1, 0, 0, 0);
    checkOutput("busy_ready",  int'(ifc.cfg_ready), 0);
    checkOutput("busy_triang", int'(ifc.triang),    1);
    applyStimulus(0, 0, 0, 1);
    applyStimulus(0, 1, 0, 0);
    checkOutput("shadow_kept_fw", int'(ifc.fw), 5);
    applyStimulus(0, 0, 0, 1);
    applyStimulus(1, 0, 0, 0);
    checkOutput("idle_cfg_sin",    int'(ifc.sin),    1);
    checkOutput("idle_cfg_triang", int'(ifc.triang), 0);
    checkOutput("idle_cfg_fw",     int'(ifc.fw),     60);

    $display("[TB] async reset mid-sweep");
    setCfg(30, 100, 3, 5, 1, 1, 1, 2);
    applyStimulus(1, 1, 0, 0);
    repeat (6) applyStimulus(0, 0, 0, 0);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("arst_fw",     int'(ifc.fw),         0);
    checkOutput("arst_busy",   int'(ifc.busy),       0);
    checkOutput("arst_ready",  int'(ifc.cfg_ready),  1);
    checkOutput("arst_triang", int'(ifc.triang),     0);
    checkOutput("arst_freq",   int'(ifc.freq_cntrl), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(0, 1, 0, 0);
    checkOutput("zero_fw",   int'(ifc.fw),   0);
    checkOutput("zero_busy", int'(ifc.busy), 1);
    applyStimulus(0, 0, 0, 0);
    checkOutput("zero_done", int'(ifc.done), 1);
    applyStimulus(0, 0, 0, 0);
    checkOutput("zero_ready", int'(ifc.cfg_ready), 1);

    $display("[TB] random traffic");
    for (int n = 0; n < 4000; n++) begin
      int st, sp;
      bit v, s, h, a;
      v = ($urandom_range(0, 7) == 0);
      s = ($urandom_range(0, 9) == 0);
      h = ($urandom_range(0, 5) == 0);
      a = ($urandom_range(0, 59) == 0);
      if (v) begin
        st = $urandom_range(0, 127);
        sp = ($urandom_range(0, 3) == 0) ? st : $urandom_range(0, 127);
        setCfg(st, sp, ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 60),
               $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
               $urandom_range(0, 3), $urandom_range(0, 7));
      end
      applyStimulus(v, s, h, a);
    end

    compareEnable = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end
endmodule
